decoder_3to8: RTL and testbench

// - 3-to-8 one-hot decoder with active-high enable; selects the LED column in the

---
 rtl/decoder_3to8.sv | 38 +++
 tb/tb_decoder_3to8.sv | 134 +++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - 3-to-8 one-hot decoder with enable and registered copy
// Drives the LED column lines; narrower consumers tap the low bits of out.
module decoder_3to8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [2:0] in,
  output logic [7:0] out,
  output logic [7:0] out_q
);

  logic [7:0] w_dec;
  logic [7:0] r_dec;

  always_comb begin
    w_dec = 8'h00;
    if (ena) begin
      for (int k = 0; k < 8; k++) begin
        if (in == 3'(k)) begin
          w_dec[k] = 1'b1;
        end
      end
    end
  end

  // Reset has priority so a same-edge input change never leaks into out_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec <= 8'h00;
    end else begin
      r_dec <= w_dec;
    end
  end

  assign out   = w_dec;
  assign out_q = r_dec;

endmodule

// File: tb/tb_decoder_3to8.sv
// tb/tb_decoder_3to8.sv - directed self-checking bench for decoder_3to8
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] in;
  logic [7:0] out;
  logic [7:0] out_q;

  int n_asserts;
  int n_fail;

  logic [7:0] onehot_tbl [8];

  decoder_3to8 dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .in    (in),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic r, input logic e, input logic [2:0] sel);
    @(negedge clk);
    rst = r;
    ena = e;
    in  = sel;
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    onehot_tbl[0] = 8'h01;
    onehot_tbl[1] = 8'h02;
    onehot_tbl[2] = 8'h04;
    onehot_tbl[3] = 8'h08;
    onehot_tbl[4] = 8'h10;
    onehot_tbl[5] = 8'h20;
    onehot_tbl[6] = 8'h40;
    onehot_tbl[7] = 8'h80;

    rst = 1'b1;
    ena = 1'b1;
    in  = 3'd3;
    step_edge();
    step_edge();
    check8("reset_out_q", out_q, 8'h00);

    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b0, 1'b0, 3'(i));
      check8($sformatf("ena0_out_in%0d", i), out, 8'h00);
      step_edge();
      check8($sformatf("ena0_out_q_in%0d", i), out_q, 8'h00);
    end

    for (int i = 0; i < 8; i++) begin
      set_inputs(1'b0, 1'b1, 3'(i));
      check8($sformatf("ena1_out_in%0d", i), out, onehot_tbl[i]);
      check_int($sformatf("ena1_popcount_in%0d", i), $countones(out), 1);
      step_edge();
      check8($sformatf("ena1_out_q_in%0d", i), out_q, onehot_tbl[i]);
    end

    set_inputs(1'b0, 1'b1, 3'd0);
    step_edge();
    check8("lat_pre", out_q, 8'h01);
    set_inputs(1'b0, 1'b1, 3'd5);
    check8("lat_not_before_edge", out_q, 8'h01);
    check8("lat_out_comb", out, 8'h20);
    step_edge();
    check8("lat_after_edge", out_q, 8'h20);

    set_inputs(1'b0, 1'b1, 3'd7);
    step_edge();
    check8("pre_rst_out_q", out_q, 8'h80);
    set_inputs(1'b1, 1'b1, 3'd2);
    check8("rst_out_comb", out, 8'h04);
    check8("rst_out_q_before_edge", out_q, 8'h80);
    step_edge();
    check8("rst_clears_out_q", out_q, 8'h00);
    check8("rst_out_comb_held", out, 8'h04);

    set_inputs(1'b0, 1'b1, 3'd2);
    check8("rst_release_before_edge", out_q, 8'h00);
    step_edge();
    check8("rst_release_out_q", out_q, 8'h04);

    set_inputs(1'b0, 1'b1, 3'd6);
    check8("col_in6_low5", {3'b000, out[4:0]}, 8'h00);
    check8("col_in6_full", out, 8'h40);
    set_inputs(1'b0, 1'b1, 3'd4);
    check8("col_in4_low5", {3'b000, out[4:0]}, 8'h10);

    set_inputs(1'b0, 1'b1, 3'd1);
    step_edge();
    check8("toggle_pre_out_q", out_q, 8'h02);
    set_inputs(1'b0, 1'b0, 3'd1);
    check8("toggle_out_drop", out, 8'h00);
    check8("toggle_out_q_hold", out_q, 8'h02);
    step_edge();
    check8("toggle_out_q_drop", out_q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
